// File: rtl/regfile32_if.sv
// Operand/writeback bundle between the MIPS datapath and regfile32.
// The master drives the write and read addresses, and the slave returns both operands.
interface regfile32_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [WIDTH-1:0]  read_data1;
    logic [WIDTH-1:0]  read_data2;

    modport master (
        output write_en, write_addr, write_data, read_addr1, read_addr2,
        input  read_data1, read_data2
    );

    modport slave (
        input  write_en, write_addr, write_data, read_addr1, read_addr2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/regfile32.sv
// 32 x 32-bit MIPS register file: two combinational reads, one clocked write, and $zero hardwired.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile32 #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    regfile32_if.slave rf
);
    localparam int NREG = 2 ** ADDR_W;

    // Register 0 has no storage; address 0 matches no row, so both reads return 0.
    logic [WIDTH-1:0] regs_q [1:NREG-1];
    logic [WIDTH-1:0] regs_d [1:NREG-1];
    wire  [NREG-1:1]  we;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    genvar g;
    generate
        for (g = 1; g < NREG; g++) begin : g_we
            wire hit;
            assign hit = (rf.write_addr == ADDR_W'(g));
            and u_we (we[g], rf.write_en, hit);
        end
    endgenerate

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we[i]) begin
                regs_d[i] = rf.write_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // AND-OR read muxes: each row is gated by its address match.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NREG; i++) begin
            rd1 = rd1 | (regs_q[i] & {WIDTH{rf.read_addr1 == ADDR_W'(i)}});
            rd2 = rd2 | (regs_q[i] & {WIDTH{rf.read_addr2 == ADDR_W'(i)}});
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic byp1;
    logic byp2;

    always_comb begin
        byp1 = rf.write_en && !reset && (rf.write_addr != '0) && (rf.read_addr1 == rf.write_addr);
        byp2 = rf.write_en && !reset && (rf.write_addr != '0) && (rf.read_addr2 == rf.write_addr);
    end

    assign rf.read_data1 = byp1 ? rf.write_data : rd1;
    assign rf.read_data2 = byp2 ? rf.write_data : rd2;
`else
    assign rf.read_data1 = rd1;
    assign rf.read_data2 = rd2;
`endif

endmodule

// File: tb/tb_regfile32.sv
// Randomised scoreboard bench for regfile32; expected operands come from an array model of the registers.
module tb_regfile32;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile32_if #(.WIDTH(32), .ADDR_W(5)) rf_if ();

    regfile32 #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_if)
    );

    always #5 clk = ~clk;

    logic [31:0] mdl [32];
    logic [31:0] exp1_q [$];
    logic [31:0] exp2_q [$];
    string       name_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          done  = 1'b0;

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd,
                                               input logic rst);
        if (rst || ra == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && wa == ra) return wd;
`else
        if (we && wa == ra && wd === 32'hx) return 32'h0;
`endif
        return mdl[ra];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, expv);
        end
    endtask

    // Drives one cycle, queues the expected operands before the edge, then commits the write to the model.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra1, input logic [4:0] ra2, input string name);
        rf_if.write_en   = we;
        rf_if.write_addr = wa;
        rf_if.write_data = wd;
        rf_if.read_addr1 = ra1;
        rf_if.read_addr2 = ra2;
        exp1_q.push_back(model_read(ra1, we, wa, wd, reset));
        exp2_q.push_back(model_read(ra2, we, wa, wd, reset));
        name_q.push_back(name);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            mdl[wa] = wd;
        end
        #1;
    endtask

    task automatic readPair(input logic [4:0] ra1, input logic [4:0] ra2, input string name);
        applyStimulus(1'b0, 5'd0, 32'h0, ra1, ra2, name);
    endtask

    always @(negedge clk) begin
        if (exp1_q.size() > 0) begin
            string nm;
            logic [31:0] e1, e2;
            nm = name_q.pop_front();
            e1 = exp1_q.pop_front();
            e2 = exp2_q.pop_front();
            checkOutput({nm, "/rd1"}, rf_if.read_data1, e1);
            checkOutput({nm, "/rd2"}, rf_if.read_data2, e2);
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("[TB] FAIL watchdog: got no completion, expected finish within 200000 ns");
            $fatal(1, "[TB] timeout");
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rf_if.write_en   = 1'b0;
        rf_if.write_addr = 5'd0;
        rf_if.write_data = 32'h0;
        rf_if.read_addr1 = 5'd0;
        rf_if.read_addr2 = 5'd0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0, "reset_blocks_write");
        reset = 1'b0;
        readPair(5'd3, 5'd17, "post_reset_zero");

        applyStimulus(1'b1, 5'd1,  32'h12345678, 5'd1, 5'd31, "write_r1");
        applyStimulus(1'b1, 5'd31, 32'hFFFFFFFF, 5'd1, 5'd31, "write_r31");
        readPair(5'd1, 5'd31, "basic_read");

        applyStimulus(1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0, "zero_write_pre");
        readPair(5'd0, 5'd0, "zero_write_post");

        applyStimulus(1'b1, 5'd7, 32'h0F0F0F0F, 5'd0, 5'd0, "write_r7");
        readPair(5'd7, 5'd7, "dual_read_r7");

        applyStimulus(1'b1, 5'd9, 32'h11111111, 5'd9, 5'd0, "write_r9_first");
        applyStimulus(1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9, "rdw_pre_edge");
        readPair(5'd9, 5'd0, "rdw_post_edge");

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "write_r5");
        #2 reset = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        applyStimulus(1'b1, 5'd5, 32'h00000001, 5'd5, 5'd1, "reset_mid_cycle");
        #2 reset = 1'b0;
        readPair(5'd5, 5'd31, "after_reset_release");

        for (int i = 1; i < 32; i++)
            applyStimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i), "sweep_write");
        for (int i = 0; i < 32; i++)
            readPair(5'(i), 5'(31 - i), "sweep_read");

        for (int n = 0; n < 300; n++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");

        @(posedge clk); #1;
        n_cmp++;
        if (exp1_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp1_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
